// File: rtl/rle_video_pkg.sv
// Shared state and token-kind definitions for the RLE video/audio stream decoder.
package rle_video_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    PIXEL,
    ROW_WAIT,
    FRAME_END
  } state_e;

  typedef enum logic [2:0] {
    TOK_PIXEL,
    TOK_ABS,
    TOK_DELTA,
    TOK_EOL,
    TOK_EOF
  } tok_e;

  localparam logic [1:0] TAG_CTRL  = 2'b11;
  localparam logic [1:0] SUB_ABS   = 2'b00;
  localparam logic [1:0] SUB_DELTA = 2'b01;
  localparam logic [1:0] SUB_EOL   = 2'b10;
  localparam logic [1:0] SUB_EOF   = 2'b11;

  function automatic tok_e decode_token(input logic [1:0] tag, input logic [1:0] sub);
    tok_e kind;
    if (tag != TAG_CTRL) begin
      kind = TOK_PIXEL;
    end else begin
      case (sub)
        SUB_ABS:   kind = TOK_ABS;
        SUB_DELTA: kind = TOK_DELTA;
        SUB_EOL:   kind = TOK_EOL;
        default:   kind = TOK_EOF;
      endcase
    end
    return kind;
  endfunction

endpackage

// File: rtl/rle_pcm_channel.sv
// One audio channel: pending sample loaded absolutely or by saturating delta,
// copied to the PWM output on each row boundary.
module rle_pcm_channel #(
  parameter int SAMPLE_W = 8,
  parameter int COLOUR_W = 6
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                load_abs,
  input  logic                load_delta,
  input  logic [SAMPLE_W-1:0] abs_val,
  input  logic [COLOUR_W-1:0] delta,
  input  logic                commit,
  output logic [SAMPLE_W-1:0] sample
);
  localparam int SUM_W = ((SAMPLE_W > COLOUR_W) ? SAMPLE_W : COLOUR_W) + 2;
  localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'((2 ** SAMPLE_W) - 1);

  logic [SAMPLE_W-1:0]     pending_q, pending_d;
  logic [SAMPLE_W-1:0]     sample_q, sample_d;
  logic signed [SUM_W-1:0] sum;

  always_comb begin
    sum = $signed({{(SUM_W-SAMPLE_W){1'b0}}, pending_q})
        + $signed({{(SUM_W-COLOUR_W){delta[COLOUR_W-1]}}, delta});
    pending_d = pending_q;
    if (load_abs) begin
      pending_d = abs_val;
    end else if (load_delta) begin
      if (sum[SUM_W-1])      pending_d = '0;
      else if (sum > MAX_S)  pending_d = '1;
      else                   pending_d = sum[SAMPLE_W-1:0];
    end
    // Commit uses the registered value, so a token taken on the same edge shows next row.
    sample_d = commit ? pending_q : sample_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pending_q <= '0;
      sample_q  <= '0;
    end else begin
      pending_q <= pending_d;
      sample_q  <= sample_d;
    end
  end

  assign sample = sample_q;

endmodule

// File: rtl/rle_video_stream.sv
// RLE token decoder between the SPI word fetcher and VGA output: pixel runs,
// row/frame markers and per-channel audio samples committed at row start.
module rle_video_stream
  import rle_video_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int COLOUR_W = 6,
  parameter int NUM_CH   = 2,
  parameter int SAMPLE_W = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       data_ready,
  input  logic [DATA_W-1:0]          data,
  output logic                       read_next,
  output logic                       stop_data,
  input  logic                       next_frame,
  input  logic                       next_row,
  input  logic                       next_pixel,
  output logic [COLOUR_W-1:0]        colour,
  output logic [NUM_CH*SAMPLE_W-1:0] pwm_sample,
  output logic                       underrun
);
  localparam int RUN_W = DATA_W - COLOUR_W;

  logic [RUN_W-1:0]    run;
  logic [COLOUR_W-1:0] low;
  logic [1:0]          ch;
  tok_e                tok;

  state_e              state_q, state_d;
  logic [RUN_W-1:0]    remaining_q, remaining_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic                read_next_q, read_next_d;
  logic                stop_data_q, stop_data_d;
  logic                underrun_q, underrun_d;
  logic                takeable, take, load_abs, load_delta;
  logic [NUM_CH-1:0][SAMPLE_W-1:0] sample;

  assign run      = data[DATA_W-1:COLOUR_W];
  assign low      = data[COLOUR_W-1:0];
  assign ch       = run[RUN_W-5:RUN_W-6];
  assign tok      = decode_token(run[RUN_W-1:RUN_W-2], run[RUN_W-3:RUN_W-4]);
  assign takeable = data_ready && !read_next_q;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    colour_d    = colour_q;
    take        = 1'b0;
    underrun_d  = 1'b0;
    if (next_frame) begin
      state_d     = FETCH;
      colour_d    = '0;
      remaining_d = '0;
    end else begin
      case (state_q)
        IDLE: ;
        FETCH: begin
          if (takeable)        take = 1'b1;
          else if (next_pixel) underrun_d = 1'b1;
        end
        PIXEL: begin
          if (next_pixel) begin
            remaining_d = remaining_q - RUN_W'(1);
            if (remaining_q == RUN_W'(1)) begin
              if (takeable) take = 1'b1;
              else          state_d = FETCH;
            end
          end
        end
        ROW_WAIT:  if (next_row) state_d = FETCH;
        FRAME_END: ;
        default:   state_d = IDLE;
      endcase
      // Decoding the fresh token here lets a run end and the next begin on one pixel.
      if (take) begin
        case (tok)
          TOK_PIXEL: begin
            state_d     = PIXEL;
            colour_d    = low;
            remaining_d = run + RUN_W'(1);
          end
          TOK_ABS, TOK_DELTA: state_d = FETCH;
          TOK_EOL: begin
            state_d  = ROW_WAIT;
            colour_d = '0;
          end
          TOK_EOF: begin
            state_d  = FRAME_END;
            colour_d = '0;
          end
          default: ;
        endcase
      end
    end
    read_next_d = take;
    stop_data_d = (state_d == IDLE) || (state_d == FRAME_END);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      colour_q    <= '0;
      read_next_q <= 1'b0;
      stop_data_q <= 1'b1;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      colour_q    <= colour_d;
      read_next_q <= read_next_d;
      stop_data_q <= stop_data_d;
      underrun_q  <= underrun_d;
    end
  end

  assign load_abs   = take && (tok == TOK_ABS);
  assign load_delta = take && (tok == TOK_DELTA);

  // The absolute payload {run[RUN_W-7:0], low} truncated is simply the low data bits.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    rle_pcm_channel #(
      .SAMPLE_W(SAMPLE_W),
      .COLOUR_W(COLOUR_W)
    ) u_ch (
      .clk       (clk),
      .rstn      (rstn),
      .load_abs  (load_abs && (ch == 2'(c))),
      .load_delta(load_delta && (ch == 2'(c))),
      .abs_val   (data[SAMPLE_W-1:0]),
      .delta     (low),
      .commit    (next_row),
      .sample    (sample[c])
    );
  end

  assign pwm_sample = sample;
  assign read_next  = read_next_q;
  assign stop_data  = stop_data_q;
  assign colour     = colour_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_rle_video_stream.sv
// Scoreboard bench for rle_video_stream: stimulus queues expected pixels and
// output snapshots; a negedge monitor pops and compares them.
module tb_rle_video_stream;
  localparam int DATA_W   = 16;
  localparam int COLOUR_W = 6;
  localparam int NUM_CH   = 2;
  localparam int SAMPLE_W = 8;

  logic                       clk = 1'b0;
  logic                       rstn = 1'b0;
  logic                       data_ready = 1'b0;
  logic [DATA_W-1:0]          data = '0;
  logic                       next_frame = 1'b0;
  logic                       next_row = 1'b0;
  logic                       next_pixel = 1'b0;
  logic                       read_next, stop_data, underrun;
  logic [COLOUR_W-1:0]        colour;
  logic [NUM_CH*SAMPLE_W-1:0] pwm_sample;

  rle_video_stream #(
    .DATA_W(DATA_W),
    .COLOUR_W(COLOUR_W),
    .NUM_CH(NUM_CH),
    .SAMPLE_W(SAMPLE_W)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .data_ready(data_ready),
    .data(data),
    .read_next(read_next),
    .stop_data(stop_data),
    .next_frame(next_frame),
    .next_row(next_row),
    .next_pixel(next_pixel),
    .colour(colour),
    .pwm_sample(pwm_sample),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  typedef struct { logic [5:0] col; bit ur; } pix_t;
  typedef struct { logic [5:0] col; logic [15:0] pwm; logic stop; int rn; } snap_t;

  pix_t        pix_q[$];
  snap_t       snap_q[$];
  logic [15:0] tok_q[$];
  logic        probe = 1'b0;
  logic        done = 1'b0;
  int          total = 0;
  int          bad = 0;
  int          rn_cnt = 0;
  int          cycles = 0;
  bit          ur_exp_next = 1'b0;
  bit          exp_ur;
  pix_t        p;
  snap_t       s;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    cycles++;
    exp_ur = ur_exp_next;
    ur_exp_next = 1'b0;
    if (exp_ur || underrun) chk("underrun", int'(underrun), int'(exp_ur));
    if (read_next) rn_cnt++;
    if (rstn && next_pixel) begin
      if (pix_q.size() == 0) begin
        total++; bad++;
        $display("FAIL pixel_unexpected: got a pixel, expected none (t=%0t)", $time);
      end else begin
        p = pix_q.pop_front();
        chk("pixel_colour", int'(colour), int'(p.col));
        ur_exp_next = p.ur;
      end
    end
    if (probe) begin
      if (snap_q.size() == 0) begin
        total++; bad++;
        $display("FAIL snap_missing: got probe, expected snapshot entry");
      end else begin
        s = snap_q.pop_front();
        chk("snap_colour", int'(colour), int'(s.col));
        chk("snap_pwm", int'(pwm_sample), int'(s.pwm));
        chk("snap_stop_data", int'(stop_data), int'(s.stop));
        chk("snap_pops", rn_cnt, s.rn);
      end
    end
    if (done || cycles > 20000) begin
      if (!done) begin
        total++; bad++;
        $display("FAIL timeout: got %0d cycles, expected completion", cycles);
      end
      chk("pix_q_drained", pix_q.size(), 0);
      chk("snap_q_drained", snap_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  task automatic refresh();
    data_ready = (tok_q.size() > 0);
    data = (tok_q.size() > 0) ? tok_q[0] : 16'h0000;
  endtask

  task automatic cyc(input logic np, input logic nr, input logic nf);
    next_pixel = np; next_row = nr; next_frame = nf;
    @(posedge clk); #1;
    next_pixel = 1'b0; next_row = 1'b0; next_frame = 1'b0; probe = 1'b0;
    if (read_next && tok_q.size() > 0) void'(tok_q.pop_front());
    refresh();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic pixel(input logic [5:0] col, input bit ur);
    pix_q.push_back('{col, ur});
    cyc(1'b1, 1'b0, 1'b0);
    idle(3);
  endtask

  task automatic snap(input logic [5:0] col, input logic [15:0] pwm, input logic stop, input int rn);
    snap_q.push_back('{col, pwm, stop, rn});
    probe = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic feed(input logic [15:0] t);
    tok_q.push_back(t);
    refresh();
  endtask

  initial begin
    @(posedge clk); #1;
    idle(3);
    snap(6'd0, 16'h0000, 1'b1, 0);
    rstn = 1'b1;
    idle(2);
    snap(6'd0, 16'h0000, 1'b1, 0);
    // IDLE must not consume while a token is presented
    feed(16'h0103); idle(3);
    snap(6'd0, 16'h0000, 1'b1, 0);
    cyc(1'b0, 1'b0, 1'b1); idle(3);
    snap(6'd3, 16'h0000, 1'b0, 1);
    repeat (5) pixel(6'd3, 1'b0);
    // back-to-back runs
    feed(16'h0001); feed(16'h0002); idle(3);
    pixel(6'd1, 1'b0);
    pixel(6'd2, 1'b0);
    snap(6'd2, 16'h0000, 1'b0, 3);
    // underrun
    feed(16'h0005); idle(3);
    pixel(6'd5, 1'b0);
    repeat (3) pixel(6'd5, 1'b1);
    snap(6'd5, 16'h0000, 1'b0, 4);
    // ABS ch1 0xA5, DELTA ch1 -3
    feed(16'hC4A5); feed(16'hD43D); idle(6);
    cyc(1'b0, 1'b1, 1'b0);
    snap(6'd5, 16'hA200, 1'b0, 6);
    // ABS ch1 0xF0, DELTA ch1 +31 clamps high, ch2 ABS ignored
    feed(16'hC4F0); feed(16'hD41F); feed(16'hC855); idle(9);
    cyc(1'b0, 1'b1, 1'b0);
    snap(6'd5, 16'hFF00, 1'b0, 9);
    // ABS ch0 0x10, then DELTA ch0 -32 clamps low, then DELTA ch1 -3 from 0xFF
    feed(16'hC010); idle(3);
    cyc(1'b0, 1'b1, 1'b0);
    snap(6'd5, 16'hFF10, 1'b0, 10);
    feed(16'hD020); idle(3);
    cyc(1'b0, 1'b1, 1'b0);
    snap(6'd5, 16'hFF00, 1'b0, 11);
    feed(16'hD43D); idle(3);
    cyc(1'b0, 1'b1, 1'b0);
    snap(6'd5, 16'hFC00, 1'b0, 12);
    // ABS taken on the same edge as next_row commits the old value
    feed(16'hC0AA);
    cyc(1'b0, 1'b1, 1'b0);
    snap(6'd5, 16'hFC00, 1'b0, 13);
    cyc(1'b0, 1'b1, 1'b0);
    snap(6'd5, 16'hFCAA, 1'b0, 13);
    // EOL holds off the next token until next_row
    feed(16'hE000); feed(16'h0104); idle(4);
    snap(6'd0, 16'hFCAA, 1'b0, 14);
    cyc(1'b0, 1'b1, 1'b0); idle(3);
    snap(6'd4, 16'hFCAA, 1'b0, 15);
    repeat (5) pixel(6'd4, 1'b0);
    // EOF raises stop_data until next_frame
    feed(16'hF000); idle(3);
    snap(6'd0, 16'hFCAA, 1'b1, 16);
    cyc(1'b0, 1'b0, 1'b1); idle(1);
    snap(6'd0, 16'hFCAA, 1'b0, 16);
    // long run (200 pixels) interrupted by reset
    feed(16'h31C7); idle(3);
    snap(6'd7, 16'hFCAA, 1'b0, 17);
    pixel(6'd7, 1'b0);
    pixel(6'd7, 1'b0);
    rstn = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    snap(6'd0, 16'h0000, 1'b1, 17);
    rstn = 1'b1;
    idle(1);
    cyc(1'b0, 1'b1, 1'b0);
    snap(6'd0, 16'h0000, 1'b1, 17);
    done = 1'b1;
    idle(5);
  end

endmodule
